serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
// PURPOSE
//   Deserialises framed serial words into WORD_W-bit parallel words for the downstream parity checker.
//   Frame format: start bit (0), WORD_W bits LSB first (last bit is the sender's even-parity bit), stop bit (1).
//   Delivers each word with its parity/frame status over a valid/ready handshake.
//   Aborts stalled frames on timeout.
// PARAMETERS
//   WORD_W   6   bits per word, including the parity bit (>=2)
//   TIMEOUT  15  max clk cycles between bit_valid strobes mid-frame; 0 disables timeout
// PORTS
//   clk         in   1       single clock; all state updates on posedge
//   rst_n       in   1       synchronous, active-low reset
//   serial_in   in   1       serial line level, sampled only when bit_valid=1
//   bit_valid   in   1       one-cycle strobe marking a bit period's sample point
//   word        out  WORD_W  assembled word; bit0 = first data bit received
//   word_valid  out  1       word/status held valid until accepted
//   word_ready  in   1       consumer accepts word when word_valid & word_ready at posedge
//   parity_err  out  1       XOR of all word bits (1 = odd count of ones); qualified by word_valid
//   frame_err   out  1       stop bit sampled as 0; qualified by word_valid
//   overrun     out  1       1-cycle pulse: a completed frame was dropped
//   timeout     out  1       1-cycle pulse: a frame was aborted by the timeout
//   busy        out  1       1 when FSM is not IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE; word=0; word_valid=0; parity_err=0; frame_err=0;
//     overrun=0; timeout=0; bit counter and gap counter=0. Reset mid-frame discards the partial frame.
//   FSM, advances only on cycles with bit_valid=1 (except the timeout abort):
//     IDLE : serial_in=0 -> DATA, bit count=0. serial_in=1 -> stay (line idle).
//     DATA : shift serial_in into bit[count]; count++. After WORD_W bits -> STOP.
//     STOP : sample stop bit -> IDLE. Commit frame (see handshake). frame_err_new = ~serial_in.
//   Gap counter: cleared on every bit_valid, and held 0 in IDLE; otherwise increments each clk.
//     If TIMEOUT!=0 and the counter reaches TIMEOUT in DATA/STOP: -> IDLE, partial word discarded, timeout=1 for 1 cycle.
//     A bit_valid on the same cycle as expiry wins: the bit is taken, the counter clears, and no timeout occurs.
//   Commit latency: word/word_valid/parity_err/frame_err update on the posedge that samples the stop bit.
//     They are visible in the following cycle.
//   Handshake:
//     - word_valid stays 1 and word/status stay stable until an accept (word_valid & word_ready).
//     - Accept with no commit in the same cycle: word_valid -> 0 next cycle; word keeps its value.
//     - Accept and commit in the same cycle: the new word loads and word_valid stays 1 (no bubble).
//     - Commit while word_valid=1 and word_ready=0: the new frame is dropped, the old word is kept, overrun=1 for 1 cycle.
//     - word_ready while word_valid=0 is ignored.
//   Frames with frame_err=1 are still delivered, with their word and parity_err.
//   A start bit is accepted on the bit_valid directly after the stop bit; no idle bit is required.
//   parity_err is computed combinationally from the committed word and registered with it: ^word.
// TESTING
//   1. Frame 0,{0,0,1,0,0,1},1; word_ready=1 -> word=6'b100100, parity_err=0, frame_err=0, word_valid high exactly 1 cycle.
//   2. Frame with data {1,0,1,1,0,0} (word 6'b001101) -> parity_err=1; stop bit=0 -> frame_err=1, word still delivered.
//   3. word_ready=0, two back-to-back frames -> first word held, overrun pulses once at second stop, word unchanged;
//      word_ready=1 then -> word_valid falls next cycle.
//   4. Start plus 3 data bits, then bit_valid silent for 15 clks -> timeout pulses once, busy=0, no word_valid;
//      the next full frame is received correctly.
//   5. rst_n=0 for 1 cycle mid-DATA and while word_valid=1 -> all outputs 0 next cycle; the frame after reset decodes correctly.
//   6. word_ready held 1 and stop-bit commit on the same cycle as the accept of the previous word
//      -> word_valid stays 1 and the new word appears with no gap.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// Serial frame deserialiser: start bit, WORD_W bits LSB first, stop bit.
// Delivers each word with parity/frame status over valid/ready; stalled frames abort on timeout.
module serial_frame_receiver #(
    parameter int WORD_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    input  logic              bit_valid,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              timeout,
    output logic              busy
);

    localparam int CW = $clog2(WORD_W);
    localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [GW-1:0]     gap;
    logic [WORD_W-1:0] shreg;
    logic              expire;
    logic              can_load;

    // Expiry is one cycle ahead of the counter so the abort lands on the TIMEOUT-th silent clock
    assign expire   = (TIMEOUT != 0) && (gap == GW'(TIMEOUT - 1));
    assign can_load = !word_valid || word_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            gap        <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            timeout <= 1'b0;
            // A commit below overrides this drop, giving back-to-back delivery with no bubble
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    gap <= '0;
                    if (bit_valid && !serial_in) begin
                        state <= DATA;
                        count <= '0;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        gap   <= '0;
                        shreg <= {serial_in, shreg[WORD_W-1:1]};
                        if (count == CW'(WORD_W - 1)) begin
                            state <= STOP;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end else if (expire) begin
                        state   <= IDLE;
                        count   <= '0;
                        gap     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                STOP: begin
                    if (bit_valid) begin
                        gap   <= '0;
                        state <= IDLE;
                        count <= '0;
                        if (can_load) begin
                            word       <= shreg;
                            word_valid <= 1'b1;
                            parity_err <= ^shreg;
                            frame_err  <= ~serial_in;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (expire) begin
                        state   <= IDLE;
                        count   <= '0;
                        gap     <= '0;
                        timeout <= 1'b1;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    gap   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: vector table, directed corner sequences,
// and randomized traffic compared every cycle against a frame-level reference model.
module tb_serial_frame_receiver;

    localparam int W  = 6;
    localparam int TO = 15;

    logic         clk;
    logic         rst_n;
    logic         serial_in;
    logic         bit_valid;
    logic [W-1:0] word;
    logic         word_valid;
    logic         word_ready;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;
    logic         timeout;
    logic         busy;

    serial_frame_receiver #(.WORD_W(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .bit_valid (bit_valid),
        .word      (word),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int passes;
    int cycle;
    int ovr_seen;
    int to_seen;

    // Reference model: frame bits collected as a list, delivered word as plain values
    int           fb[$];
    int           silent;
    logic [W-1:0] m_word;
    logic         m_wv;
    logic         m_pe;
    logic         m_fe;
    logic         m_ovr;
    logic         m_to;

    typedef struct {
        logic         r;
        logic         bv;
        logic         si;
        logic         rdy;
        logic         wv;
        logic [W-1:0] w;
        logic         pe;
        logic         fe;
        logic         bsy;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic bv, logic si, logic rdy,
                                logic wv, logic [W-1:0] w, logic pe, logic fe, logic bsy);
        vec_t v;
        v.r = r; v.bv = bv; v.si = si; v.rdy = rdy;
        v.wv = wv; v.w = w; v.pe = pe; v.fe = fe; v.bsy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    task automatic modelUpdate(input logic r, input logic bv, input logic si, input logic rdy);
        logic         commit;
        logic [W-1:0] nw;
        logic         nfe;
        commit = 1'b0;
        nw     = '0;
        nfe    = 1'b0;
        m_ovr  = 1'b0;
        m_to   = 1'b0;
        if (!r) begin
            fb.delete();
            silent = 0;
            m_word = '0;
            m_wv   = 1'b0;
            m_pe   = 1'b0;
            m_fe   = 1'b0;
            return;
        end
        if (fb.size() == 0) begin
            silent = 0;
            if (bv && !si) fb.push_back(0);
        end else if (bv) begin
            silent = 0;
            fb.push_back(int'(si));
            if (fb.size() == W + 2) begin
                for (int i = 0; i < W; i++) nw[i] = fb[i + 1][0];
                nfe    = (si == 1'b0);
                commit = 1'b1;
                fb.delete();
            end
        end else begin
            silent++;
            if (silent == TO) begin
                fb.delete();
                silent = 0;
                m_to   = 1'b1;
            end
        end
        if (commit) begin
            if (!m_wv || rdy) begin
                m_word = nw;
                m_wv   = 1'b1;
                m_pe   = ($countones(nw) % 2) == 1;
                m_fe   = nfe;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_wv && rdy) begin
            m_wv = 1'b0;
        end
    endtask

    task automatic checkOutput();
        check("word_valid", 32'(word_valid), 32'(m_wv));
        check("word",       32'(word),       32'(m_word));
        check("parity_err", 32'(parity_err), 32'(m_pe));
        check("frame_err",  32'(frame_err),  32'(m_fe));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("timeout",    32'(timeout),    32'(m_to));
        check("busy",       32'(busy),       32'(fb.size() != 0));
        if (overrun === 1'b1) ovr_seen++;
        if (timeout === 1'b1) to_seen++;
    endtask

    task automatic applyStimulus(input logic r, input logic bv, input logic si, input logic rdy);
        rst_n      = r;
        bit_valid  = bv;
        serial_in  = si;
        word_ready = rdy;
        @(posedge clk);
        modelUpdate(r, bv, si, rdy);
        #1;
        cycle++;
        checkOutput();
    endtask

    task automatic sendFrame(input logic [W-1:0] data, input logic stop_bit,
                             input logic rdy, input logic rdy_stop, input int gap_cycles);
        applyStimulus(1'b1, 1'b1, 1'b0, rdy);
        for (int i = 0; i < W; i++) begin
            for (int g = 0; g < gap_cycles; g++) applyStimulus(1'b1, 1'b0, 1'b1, rdy);
            applyStimulus(1'b1, 1'b1, data[i], rdy);
        end
        for (int g = 0; g < gap_cycles; g++) applyStimulus(1'b1, 1'b0, 1'b1, rdy);
        applyStimulus(1'b1, 1'b1, stop_bit, rdy_stop);
    endtask

    initial begin
        checks = 0; passes = 0; cycle = 0; ovr_seen = 0; to_seen = 0;
        silent = 0;
        m_word = '0; m_wv = 0; m_pe = 0; m_fe = 0; m_ovr = 0; m_to = 0;
        rst_n = 1'b0; bit_valid = 1'b0; serial_in = 1'b1; word_ready = 1'b0;

        vecs[0]  = mk(0, 0, 1, 0,  0, 6'h00, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 1,  0, 6'h00, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 1,  0, 6'h00, 0, 0, 1);
        vecs[3]  = mk(1, 1, 0, 1,  0, 6'h00, 0, 0, 1);
        vecs[4]  = mk(1, 1, 0, 1,  0, 6'h00, 0, 0, 1);
        vecs[5]  = mk(1, 1, 1, 1,  0, 6'h00, 0, 0, 1);
        vecs[6]  = mk(1, 1, 0, 1,  0, 6'h00, 0, 0, 1);
        vecs[7]  = mk(1, 1, 0, 1,  0, 6'h00, 0, 0, 1);
        vecs[8]  = mk(1, 1, 1, 1,  0, 6'h00, 0, 0, 1);
        vecs[9]  = mk(1, 1, 1, 1,  1, 6'h24, 0, 0, 0);
        vecs[10] = mk(1, 0, 0, 1,  0, 6'h24, 0, 0, 0);
        vecs[11] = mk(1, 1, 0, 1,  0, 6'h24, 0, 0, 1);
        vecs[12] = mk(1, 1, 1, 1,  0, 6'h24, 0, 0, 1);
        vecs[13] = mk(1, 1, 0, 1,  0, 6'h24, 0, 0, 1);
        vecs[14] = mk(1, 1, 1, 1,  0, 6'h24, 0, 0, 1);
        vecs[15] = mk(1, 1, 1, 1,  0, 6'h24, 0, 0, 1);
        vecs[16] = mk(1, 1, 0, 1,  0, 6'h24, 0, 0, 1);
        vecs[17] = mk(1, 1, 0, 1,  0, 6'h24, 0, 0, 1);
        vecs[18] = mk(1, 1, 0, 1,  1, 6'h0D, 1, 1, 0);
        vecs[19] = mk(1, 1, 1, 1,  0, 6'h0D, 1, 1, 0);

        // Reset, a clean frame, then a parity-error frame with a bad stop bit
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].r, vecs[i].bv, vecs[i].si, vecs[i].rdy);
            check("tbl_word_valid", 32'(word_valid), 32'(vecs[i].wv));
            check("tbl_word",       32'(word),       32'(vecs[i].w));
            check("tbl_parity_err", 32'(parity_err), 32'(vecs[i].pe));
            check("tbl_frame_err",  32'(frame_err),  32'(vecs[i].fe));
            check("tbl_busy",       32'(busy),       32'(vecs[i].bsy));
        end

        // Held word, second frame overruns and is dropped
        ovr_seen = 0;
        sendFrame(6'h15, 1'b1, 1'b0, 1'b0, 1);
        sendFrame(6'h2A, 1'b1, 1'b0, 1'b0, 0);
        check("ovr_count", 32'(ovr_seen), 32'd1);
        check("ovr_word_kept", 32'(word), 32'h15);
        check("ovr_valid_held", 32'(word_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        check("ovr_accept_drop", 32'(word_valid), 32'd0);

        // Stalled frame times out after TO silent clocks
        to_seen = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'(i % 2), 1'b1);
        for (int i = 0; i < TO; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        check("to_count", 32'(to_seen), 32'd1);
        check("to_no_valid", 32'(word_valid), 32'd0);
        sendFrame(6'h33, 1'b1, 1'b0, 1'b0, 2);
        check("to_next_word", 32'(word), 32'h33);
        check("to_next_valid", 32'(word_valid), 32'd1);

        // Reset mid-frame while a word is held
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", 32'(word), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        sendFrame(6'h0B, 1'b1, 1'b0, 1'b0, 0);
        check("rst_next_word", 32'(word), 32'h0B);
        check("rst_next_parity", 32'(parity_err), 32'd1);

        // Accept and commit on the same edge: no bubble
        sendFrame(6'h3C, 1'b1, 1'b0, 1'b1, 0);
        check("nb_valid", 32'(word_valid), 32'd1);
        check("nb_word", 32'(word), 32'h3C);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        check("nb_drop", 32'(word_valid), 32'd0);

        // Randomized traffic with periodic silent windows to provoke timeouts
        for (int c = 0; c < 4000; c++) begin
            logic r, bv, si, rdy;
            int   ph;
            ph  = c % 200;
            r   = ($urandom_range(0, 299) != 0);
            bv  = (ph >= 150 && ph < 168) ? 1'b0 : ($urandom_range(0, 2) == 0);
            si  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) == 1);
            applyStimulus(r, bv, si, rdy);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
